program_counter_rel: RTL and testbench

PROGRAM_COUNTER_REL -- requirements
Module: program_counter_rel

---
 rtl/program_counter_rel_if.sv | 49 ++++
 rtl/program_counter_rel.sv | 227 ++++++++++++++++++++++
 tb/tb_program_counter_rel.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_counter_rel_if.sv
`default_nettype none
// ============================================================================
// Module      : program_counter_rel_if
// Description : Control, address-bus and status bundle for program_counter_rel.
//               The master drives selects, strobes and bus requests. The slave
//               (the PC block) drives bus data, enables and branch status.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_counter_rel_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              phase_2_rising;
    logic              pcl_pcl;
    logic              adl_pcl;
    logic              pch_pch;
    logic              adh_pch;
    logic              increment_pc;
    logic              branch_req;
    logic [7:0]        branch_offset;
    logic [7:0]        adl_in;
    logic [ADDR_W-9:0] adh_in;
    logic              pcl_db;
    logic              pch_db;
    logic              pcl_adl;
    logic              pch_adh;
    logic [7:0]        adl_out;
    logic [ADDR_W-9:0] adh_out;
    logic [7:0]        db_out;
    logic              adl_oe;
    logic              adh_oe;
    logic              db_oe;
    logic              page_cross;
    logic              busy;

    modport master (
        output phase_2_rising, pcl_pcl, adl_pcl, pch_pch, adh_pch, increment_pc,
               branch_req, branch_offset, adl_in, adh_in,
               pcl_db, pch_db, pcl_adl, pch_adh,
        input  adl_out, adh_out, db_out, adl_oe, adh_oe, db_oe, page_cross, busy
    );

    modport slave (
        input  phase_2_rising, pcl_pcl, adl_pcl, pch_pch, adh_pch, increment_pc,
               branch_req, branch_offset, adl_in, adh_in,
               pcl_db, pch_db, pcl_adl, pch_adh,
        output adl_out, adh_out, db_out, adl_oe, adh_oe, db_oe, page_cross, busy
    );
endinterface
`default_nettype wire

// File: rtl/program_counter_rel.sv
`default_nettype none
// ============================================================================
// Module      : program_counter_rel
// Description : Program counter with a select register, phase-2 load with
//               optional increment, and 8-bit relative branches. A branch that
//               crosses a page takes one extra phase-2 to fix the high part.
//               The branch logic is built only when PC_BRANCH_EN is defined.
//               Without it, branch inputs are ignored and the status is held
//               at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter_rel #(
    parameter int unsigned        ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  wire logic                   sys_clock,
    input  wire logic                   reset_n,
    program_counter_rel_if.slave        bus
);

    localparam int unsigned c_HI_W = ADDR_W - 8;

    // Registered PC and select value, split at the page boundary
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_sel_lo;
    logic [c_HI_W-1:0] r_sel_hi;

    // Previous levels of the select strobes
    logic r_pcl_pcl_q;
    logic r_adl_pcl_q;
    logic r_pch_pch_q;
    logic r_adh_pch_q;

    logic w_pcl_pcl_rise;
    logic w_adl_pcl_rise;
    logic w_pch_pch_rise;
    logic w_adh_pch_rise;
    logic w_normal_load;
    logic [ADDR_W-1:0] w_load_val;
    logic [7:0]        w_pc_b1;

    assign w_pcl_pcl_rise = bus.pcl_pcl & ~r_pcl_pcl_q;
    assign w_adl_pcl_rise = bus.adl_pcl & ~r_adl_pcl_q;
    assign w_pch_pch_rise = bus.pch_pch & ~r_pch_pch_q;
    assign w_adh_pch_rise = bus.adh_pch & ~r_adh_pch_q;

    // Select plus optional increment; the add wraps naturally at ADDR_W bits
    assign w_load_val = {r_sel_hi, r_sel_lo} + ADDR_W'(bus.increment_pc);

    // Edge-detect history for the select strobes
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pcl_pcl_q <= 1'b0;
            r_adl_pcl_q <= 1'b0;
            r_pch_pch_q <= 1'b0;
            r_adh_pch_q <= 1'b0;
        end else begin
            r_pcl_pcl_q <= bus.pcl_pcl;
            r_adl_pcl_q <= bus.adl_pcl;
            r_pch_pch_q <= bus.pch_pch;
            r_adh_pch_q <= bus.adh_pch;
        end
    end

`ifdef PC_BRANCH_EN
    localparam logic [0:0]        c_IDLE   = 1'b0;
    localparam logic [0:0]        c_FIX    = 1'b1;
    localparam logic [c_HI_W-1:0] c_HI_ONE = c_HI_W'(1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_branch_q;
    logic              r_pending;
    logic [7:0]        r_offset;
    logic              r_fix_dec;
    logic              w_br_rise;
    logic              w_take_branch;
    logic              w_fix_step;
    logic [8:0]        w_sum9;
    logic              w_cross;
    logic [c_HI_W-1:0] w_pc_hi_fixed;

    assign w_br_rise     = bus.branch_req & ~r_branch_q;
    assign w_take_branch = bus.phase_2_rising && (r_state == c_IDLE) && r_pending;
    assign w_fix_step    = bus.phase_2_rising && (r_state == c_FIX);
    assign w_normal_load = bus.phase_2_rising && (r_state == c_IDLE) && !r_pending;

    // The 9th bit is the carry; with a negative offset a missing carry is a borrow
    assign w_sum9        = {1'b0, r_pc[7:0]} + {1'b0, r_offset};
    assign w_cross       = r_offset[7] ? ~w_sum9[8] : w_sum9[8];
    assign w_pc_hi_fixed = r_fix_dec ? (r_pc[ADDR_W-1:8] - c_HI_ONE)
                                     : (r_pc[ADDR_W-1:8] + c_HI_ONE);

    // Branch state register
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a page-crossing branch detours through FIX for one phase-2
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_take_branch && w_cross) w_state_nxt = c_FIX;
            c_FIX:   if (w_fix_step)               w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Status outputs: busy covers both a queued branch and the fix-up cycle
    always_comb begin
        bus.page_cross = (r_state == c_FIX);
        bus.busy       = r_pending || (r_state == c_FIX);
    end

    // Branch request capture; a new request outranks consuming the old one
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_branch_q <= 1'b0;
            r_pending  <= 1'b0;
            r_offset   <= 8'h00;
            r_fix_dec  <= 1'b0;
        end else begin
            r_branch_q <= bus.branch_req;
            if (w_br_rise) begin
                r_pending <= 1'b1;
                r_offset  <= bus.branch_offset;
            end else if (w_take_branch) begin
                r_pending <= 1'b0;
            end
            if (w_take_branch) begin
                r_fix_dec <= r_offset[7];
            end
        end
    end

    // PC and select datapath; branch writes of select override strobe updates
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_ADDR;
            r_sel_lo <= RESET_ADDR[7:0];
            r_sel_hi <= RESET_ADDR[ADDR_W-1:8];
        end else begin
            if (w_pcl_pcl_rise) begin
                r_sel_lo <= r_pc[7:0];
            end else if (w_adl_pcl_rise) begin
                r_sel_lo <= bus.adl_in;
            end
            if (w_pch_pch_rise) begin
                r_sel_hi <= r_pc[ADDR_W-1:8];
            end else if (w_adh_pch_rise) begin
                r_sel_hi <= bus.adh_in;
            end
            if (w_normal_load) begin
                r_pc <= w_load_val;
            end
            if (w_take_branch) begin
                r_pc[7:0] <= w_sum9[7:0];
                if (!w_cross) begin
                    r_sel_lo <= w_sum9[7:0];
                    r_sel_hi <= r_pc[ADDR_W-1:8];
                end
            end
            if (w_fix_step) begin
                r_pc[ADDR_W-1:8] <= w_pc_hi_fixed;
                r_sel_hi         <= w_pc_hi_fixed;
                r_sel_lo         <= r_pc[7:0];
            end
        end
    end
`else
    assign w_normal_load = bus.phase_2_rising;

    // No branch engine: status is permanently idle
    always_comb begin
        bus.page_cross = 1'b0;
        bus.busy       = 1'b0;
    end

    // PC and select datapath
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_ADDR;
            r_sel_lo <= RESET_ADDR[7:0];
            r_sel_hi <= RESET_ADDR[ADDR_W-1:8];
        end else begin
            if (w_pcl_pcl_rise) begin
                r_sel_lo <= r_pc[7:0];
            end else if (w_adl_pcl_rise) begin
                r_sel_lo <= bus.adl_in;
            end
            if (w_pch_pch_rise) begin
                r_sel_hi <= r_pc[ADDR_W-1:8];
            end else if (w_adh_pch_rise) begin
                r_sel_hi <= bus.adh_in;
            end
            if (w_normal_load) begin
                r_pc <= w_load_val;
            end
        end
    end
`endif

    // Second PC byte for the data bus, zero-padded on narrow PCs
    generate
        if (ADDR_W >= 16) begin : g_b1_full
            assign w_pc_b1 = r_pc[15:8];
        end else begin : g_b1_pad
            assign w_pc_b1 = {{(16 - ADDR_W){1'b0}}, r_pc[ADDR_W-1:8]};
        end
    endgenerate

    // Bus drivers follow the PC combinationally so reset shows up at once
    always_comb begin
        bus.adl_out = r_pc[7:0];
        bus.adh_out = r_pc[ADDR_W-1:8];
        bus.adl_oe  = bus.pcl_adl;
        bus.adh_oe  = bus.pch_adh;
        bus.db_oe   = bus.pch_db | bus.pcl_db;
        bus.db_out  = bus.pch_db ? w_pc_b1 : r_pc[7:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_program_counter_rel.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter_rel
// Description : Self-checking bench for program_counter_rel (16-bit PC,
//               reset address FFFC). Expected PC values are queued when the
//               stimulus is applied and compared when the DUT has responded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter_rel;

    logic sys_clock = 1'b0;
    logic reset_n   = 1'b0;
    int   n_vec     = 0;
    int   n_bad     = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    program_counter_rel_if #(.ADDR_W(16)) bus ();

    program_counter_rel #(
        .ADDR_W     (16),
        .RESET_ADDR (16'hFFFC)
    ) dut (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 sys_clock = ~sys_clock;

    function automatic logic [15:0] pc_now();
        return {bus.adh_out, bus.adl_out};
    endfunction

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic pulse_p2(input logic inc);
        bus.phase_2_rising = 1'b1;
        bus.increment_pc   = inc;
        tick();
        bus.phase_2_rising = 1'b0;
        bus.increment_pc   = 1'b0;
    endtask

    task automatic set_sel(input logic [7:0] lo, input logic [7:0] hi);
        bus.adl_in  = lo;
        bus.adh_in  = hi;
        bus.adl_pcl = 1'b1;
        bus.adh_pch = 1'b1;
        tick();
        bus.adl_pcl = 1'b0;
        bus.adh_pch = 1'b0;
        tick();
    endtask

    task automatic req_branch(input logic [7:0] off);
        bus.branch_offset = off;
        bus.branch_req    = 1'b1;
        tick();
        bus.branch_req    = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge sys_clock);
        #1;
        n_vec++;
        if (pc_now() !== 16'hFFFC) begin n_bad++; $display("FAIL reset_pc got=%h want=FFFC", pc_now()); end
        n_vec++;
        if ({bus.page_cross, bus.busy, bus.db_oe} !== 3'b000) begin
            n_bad++; $display("FAIL reset_status got=%b want=000", {bus.page_cross, bus.busy, bus.db_oe});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_increment();
        exp_q.push_back(16'hFFFD);
        pulse_p2(1'b1);
        e = exp_q.pop_front(); n_vec++;
        if (pc_now() !== e) begin n_bad++; $display("FAIL inc_first got=%h want=%h", pc_now(), e); end
        exp_q.push_back(16'hFFFD);
        pulse_p2(1'b1);
        e = exp_q.pop_front(); n_vec++;
        if (pc_now() !== e) begin n_bad++; $display("FAIL inc_repeat got=%h want=%h", pc_now(), e); end
    endtask

    task automatic test_bus_load();
        set_sel(8'h34, 8'h12);
        exp_q.push_back(16'h1234);
        pulse_p2(1'b0);
        e = exp_q.pop_front(); n_vec++;
        if (pc_now() !== e) begin n_bad++; $display("FAIL bus_load got=%h want=%h", pc_now(), e); end
        bus.pcl_adl = 1'b1;
        #1;
        n_vec++;
        if ({bus.adl_oe, bus.adh_oe, bus.adl_out} !== {2'b10, 8'h34}) begin
            n_bad++; $display("FAIL adl_drive got=%b%b/%h want=10/34", bus.adl_oe, bus.adh_oe, bus.adl_out);
        end
        bus.pcl_adl = 1'b0;
        bus.pcl_db  = 1'b1;
        #1;
        n_vec++;
        if ({bus.db_oe, bus.db_out} !== {1'b1, 8'h34}) begin
            n_bad++; $display("FAIL db_low got=%b/%h want=1/34", bus.db_oe, bus.db_out);
        end
        bus.pch_db = 1'b1;
        #1;
        n_vec++;
        if ({bus.db_oe, bus.db_out} !== {1'b1, 8'h12}) begin
            n_bad++; $display("FAIL db_high_prio got=%b/%h want=1/12", bus.db_oe, bus.db_out);
        end
        bus.pcl_db = 1'b0;
        bus.pch_db = 1'b0;
        #1;
        n_vec++;
        if (bus.db_oe !== 1'b0) begin n_bad++; $display("FAIL db_off got=%b want=0", bus.db_oe); end
    endtask

    task automatic test_wrap();
        set_sel(8'hFF, 8'hFF);
        exp_q.push_back(16'h0000);
        pulse_p2(1'b1);
        e = exp_q.pop_front(); n_vec++;
        if (pc_now() !== e) begin n_bad++; $display("FAIL wrap got=%h want=%h", pc_now(), e); end
    endtask

    // PC-copy selects must beat bus selects raised in the same cycle
    task automatic test_select_priority();
        set_sel(8'h56, 8'h78);
        bus.adl_in  = 8'hAA;
        bus.adh_in  = 8'hBB;
        bus.pcl_pcl = 1'b1; bus.adl_pcl = 1'b1;
        bus.pch_pch = 1'b1; bus.adh_pch = 1'b1;
        tick();
        bus.pcl_pcl = 1'b0; bus.adl_pcl = 1'b0;
        bus.pch_pch = 1'b0; bus.adh_pch = 1'b0;
        tick();
        exp_q.push_back(16'h0001);
        pulse_p2(1'b1);
        e = exp_q.pop_front(); n_vec++;
        if (pc_now() !== e) begin n_bad++; $display("FAIL sel_priority got=%h want=%h", pc_now(), e); end
    endtask

`ifdef PC_BRANCH_EN
    task automatic test_branch_same_page();
        set_sel(8'h10, 8'h12);
        pulse_p2(1'b0);
        req_branch(8'h05);
        n_vec++;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL pend_busy got=%b want=1", bus.busy); end
        exp_q.push_back(16'h1215);
        pulse_p2(1'b1);
        e = exp_q.pop_front(); n_vec++;
        if ({pc_now(), bus.page_cross, bus.busy} !== {e, 2'b00}) begin
            n_bad++; $display("FAIL br_same got=%h/%b%b want=%h/00", pc_now(), bus.page_cross, bus.busy, e);
        end
        exp_q.push_back(16'h1215);
        pulse_p2(1'b0);
        e = exp_q.pop_front(); n_vec++;
        if ({pc_now(), bus.page_cross} !== {e, 1'b0}) begin
            n_bad++; $display("FAIL br_same_sel got=%h/%b want=%h/0", pc_now(), bus.page_cross, e);
        end
    endtask

    task automatic test_branch_cross(input logic [7:0] lo, input logic [7:0] off,
                                     input logic [15:0] mid, input logic [15:0] fin);
        set_sel(lo, 8'h12);
        pulse_p2(1'b0);
        req_branch(off);
        exp_q.push_back(mid);
        pulse_p2(1'b0);
        e = exp_q.pop_front(); n_vec++;
        if ({pc_now(), bus.page_cross, bus.busy} !== {e, 2'b11}) begin
            n_bad++; $display("FAIL br_cross_mid got=%h/%b%b want=%h/11", pc_now(), bus.page_cross, bus.busy, e);
        end
        exp_q.push_back(fin);
        pulse_p2(1'b0);
        e = exp_q.pop_front(); n_vec++;
        if ({pc_now(), bus.page_cross, bus.busy} !== {e, 2'b00}) begin
            n_bad++; $display("FAIL br_cross_fix got=%h/%b%b want=%h/00", pc_now(), bus.page_cross, bus.busy, e);
        end
        exp_q.push_back(fin);
        pulse_p2(1'b0);
        e = exp_q.pop_front(); n_vec++;
        if (pc_now() !== e) begin n_bad++; $display("FAIL br_cross_sel got=%h want=%h", pc_now(), e); end
    endtask

    // A request raised with phase-2 waits for the following phase-2
    task automatic test_back_to_back();
        set_sel(8'h10, 8'h12);
        bus.branch_offset = 8'h01;
        bus.branch_req    = 1'b1;
        exp_q.push_back(16'h1210);
        pulse_p2(1'b0);
        bus.branch_req    = 1'b0;
        e = exp_q.pop_front(); n_vec++;
        if ({pc_now(), bus.busy} !== {e, 1'b1}) begin
            n_bad++; $display("FAIL coincide_load got=%h/%b want=%h/1", pc_now(), bus.busy, e);
        end
        exp_q.push_back(16'h1211);
        pulse_p2(1'b0);
        e = exp_q.pop_front(); n_vec++;
        if ({pc_now(), bus.busy} !== {e, 1'b0}) begin
            n_bad++; $display("FAIL coincide_branch got=%h/%b want=%h/0", pc_now(), bus.busy, e);
        end
    endtask

    task automatic test_reset_in_fix();
        set_sel(8'hF0, 8'h12);
        pulse_p2(1'b0);
        req_branch(8'h20);
        pulse_p2(1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({pc_now(), bus.busy, bus.page_cross} !== {16'hFFFC, 2'b00}) begin
            n_bad++; $display("FAIL reset_in_fix got=%h/%b%b want=FFFC/00", pc_now(), bus.busy, bus.page_cross);
        end
        tick();
        reset_n = 1'b1;
        exp_q.push_back(16'hFFFC);
        pulse_p2(1'b0);
        e = exp_q.pop_front(); n_vec++;
        if ({pc_now(), bus.busy} !== {e, 1'b0}) begin
            n_bad++; $display("FAIL after_abort got=%h/%b want=%h/0", pc_now(), bus.busy, e);
        end
    endtask
`else
    task automatic test_branch_ignored();
        set_sel(8'h10, 8'h12);
        pulse_p2(1'b0);
        req_branch(8'h05);
        n_vec++;
        if ({bus.busy, bus.page_cross} !== 2'b00) begin
            n_bad++; $display("FAIL nobr_status got=%b%b want=00", bus.busy, bus.page_cross);
        end
        exp_q.push_back(16'h1211);
        pulse_p2(1'b1);
        e = exp_q.pop_front(); n_vec++;
        if (pc_now() !== e) begin n_bad++; $display("FAIL nobr_pc got=%h want=%h", pc_now(), e); end
    endtask

    task automatic test_async_reset();
        set_sel(8'h20, 8'h13);
        pulse_p2(1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({pc_now(), bus.busy} !== {16'hFFFC, 1'b0}) begin
            n_bad++; $display("FAIL async_reset got=%h/%b want=FFFC/0", pc_now(), bus.busy);
        end
        tick();
        reset_n = 1'b1;
        exp_q.push_back(16'hFFFD);
        pulse_p2(1'b1);
        e = exp_q.pop_front(); n_vec++;
        if (pc_now() !== e) begin n_bad++; $display("FAIL after_reset got=%h want=%h", pc_now(), e); end
    endtask
`endif

    initial begin
        bus.phase_2_rising = 1'b0; bus.increment_pc = 1'b0;
        bus.pcl_pcl = 1'b0; bus.adl_pcl = 1'b0; bus.pch_pch = 1'b0; bus.adh_pch = 1'b0;
        bus.branch_req = 1'b0; bus.branch_offset = 8'h00;
        bus.adl_in = 8'h00; bus.adh_in = 8'h00;
        bus.pcl_db = 1'b0; bus.pch_db = 1'b0; bus.pcl_adl = 1'b0; bus.pch_adh = 1'b0;

        test_reset();
        test_increment();
        test_bus_load();
        test_wrap();
        test_select_priority();
`ifdef PC_BRANCH_EN
        test_branch_same_page();
        test_branch_cross(8'hF0, 8'h20, 16'h1210, 16'h1310);
        test_branch_cross(8'h05, 8'hF0, 16'h12F5, 16'h11F5);
        test_back_to_back();
        test_reset_in_fix();
`else
        test_branch_ignored();
        test_async_reset();
`endif
        if (exp_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
